window_gen_3x3: RTL
===================

// Module: window_gen_3x3
// PURPOSE
//  Upstream stage of the median filter. Takes a raster-order 8-bit pixel stream
//  (from image RAM readout) and presents complete 3x3 neighbourhoods, one per
//  interior pixel, to the median sorter. Row history is held in two line buffers.
//  The block emits exactly (H-2)*(W-2) windows per frame (9604 at 100x100).
// PARAMETERS
//  IMG_W  100  pixels per row (>=3)
//  IMG_H  100  rows per frame (>=3)
//  PIX_W  8    bits per pixel
// PORTS
//  clk         in   1        single clock, all logic on rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  start       in   1        1-cycle pulse: abort current frame, expect pixel (0,0) next
//  in_valid    in   1        pix_data valid
//  in_ready    out  1        block accepts pixel this cycle
//  pix_data    in   PIX_W    pixel, raster order row 0 col 0 first
//  out_valid   out  1        win_data/win_x/win_y valid
//  out_ready   in   1        median sorter consumes window this cycle
//  win_data    out  9*PIX_W  taps m1..m9 row-major; m1 (top-left) in [7:0], m5 = centre
//  win_x       out  7        centre column, 1..IMG_W-2
//  win_y       out  7        centre row, 1..IMG_H-2
//  frame_done  out  1        1-cycle pulse when last window of frame is consumed
// BEHAVIOUR
//  - Reset: in_ready=0 in reset then 1; out_valid=0, win_data=0, win_x=0, win_y=0,
//    frame_done=0; col=row=0; line buffers not cleared (contents don't-care).
//  - Accept: pixel accepted when in_valid && in_ready. in_ready = !out_valid || out_ready,
//    forced 0 in any cycle where start=1.
//  - Per accepted pixel at (row,col): new column {lb1[col], lb0[col], pix};
//    window shifts left one column; lb1[col]<=lb0[col]; lb0[col]<=pix.
//  - Counters: col increments, wraps IMG_W-1 -> 0 with row++; row IMG_H-1 at col
//    IMG_W-1 wraps to row 0 (next frame starts without start pulse).
//  - Emit: if row>=2 && col>=2, out_valid<=1 next cycle with win_x=col-1, win_y=row-1.
//    Latency 1 cycle pixel-accept -> out_valid. Columns 0,1 of each row never emit
//    (window straddles rows). Rows 0,1 fill buffers only.
//  - Hold: out_valid && !out_ready -> win_data/win_x/win_y stable, no pixel accepted.
//    out_valid drops after consume unless a new window is loaded same cycle.
//  - frame_done: pulses the cycle the (IMG_W-2, IMG_H-2) window is consumed.
//  - start: clears col/row, out_valid<=0 (pending window discarded), frame_done not
//    raised. start together with in_valid: start wins, pixel not accepted.
//  - reset mid-frame: all above reset values, identical to power-up.
//  - Coordinate arithmetic unsigned 7-bit; IMG_W/IMG_H <=128.
//  - FSM: IDLE (after reset, in_ready=1, waiting first pixel) -> FILL (rows 0-1)
//    -> STREAM (row>=2) -> back to FILL on frame wrap or start; IDLE only via reset.
// STRUCTURE
//  - Package img_pkg: IMG_W, IMG_H, PIX_W defaults, typedef pixel_t (logic[7:0]),
//    typedef window_t (pixel_t [0:8]), coord_t (logic[6:0]).
//  - Sub-module line_buffer: IMG_W-deep PIX_W register/RAM row delay, read-before-write
//    at same index; instanced twice (lb0, lb1).
//  - Top: counters, FSM, 3x3 window register, output register/handshake.
// TESTING
//  - Ramp frame pix=(row+col)&FF, out_ready=1 -> 9604 windows, first win_x=1,win_y=1,
//    m1=00 m5=02 m9=04; last win (98,98) m5=C4; frame_done once.
//  - Constant 0x80 frame with single 0xFF at (50,50) -> nine windows containing it,
//    each exactly one 0xFF tap at correct position; all others all-0x80.
//  - Random out_ready (50%) backpressure -> same window sequence as free-run, win
//    fields stable while stalled, no pixel accepted while out_valid&&!out_ready.
//  - start pulse at pixel (40,17) then full frame -> no window with stale data; first
//    window after start is (1,1); start+in_valid same cycle -> that pixel dropped.
//  - reset asserted mid-STREAM (async, between edges) -> outputs zero immediately;
//    next frame produces correct 9604 windows.
//  - Two back-to-back frames with no start -> second frame windows correct, 2 frame_done.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-geometry defaults and types for the median-filter front end.
//   DEF_IMG_W / DEF_IMG_H : default frame size in pixels
//   DEF_PIX_W             : default pixel width in bits
//   pixel_t, window_t     : one pixel and a full 3x3 neighbourhood (m1..m9)
//   coord_t               : 7-bit unsigned pixel coordinate
//   wg_state_t            : window generator control states
package img_pkg;

  localparam int DEF_IMG_W = 100;
  localparam int DEF_IMG_H = 100;
  localparam int DEF_PIX_W = 8;

  typedef logic [7:0]     pixel_t;
  typedef pixel_t [0:8]   window_t;
  typedef logic [6:0]     coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } wg_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel delay.
//   clk      : clock
//   we       : write enable (one accepted pixel)
//   idx      : column index, shared by read and write
//   wr_data  : pixel written at idx
//   rd_data  : pixel stored at idx before this cycle's write (read-before-write)
// Contents are never cleared; they are always overwritten before being used.
module line_buffer #(
  parameter int DEPTH = 100,
  parameter int PIX_W = 8,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[idx];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wr_data;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 window generator feeding the median sorter.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : abort current frame, next accepted pixel is (0,0)
//   in_valid / in_ready / pix_data : raster-order pixel stream in
//   out_valid / out_ready          : window handshake out
//   win_data    : taps m1..m9 row-major, m1 (top-left) in the low byte
//   win_x/win_y : centre coordinates of the presented window
//   frame_done  : pulse when the last window of a frame is consumed
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] win_data,
  output coord_t             win_x,
  output coord_t             win_y,
  output logic               frame_done
);

  wg_state_t        state_q, state_d;
  coord_t           col_q, col_d, row_q, row_d;
  coord_t           win_x_q, win_x_d, win_y_q, win_y_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic             accept, emit;

  assign in_ready = !reset && !start && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // STREAM tracks row>=2, so only the column needs checking here.
  assign emit     = accept && (state_q == ST_STREAM) && (col_q >= 7'd2);

  // lb0 holds the previous row, lb1 the row before that.
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(7)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .idx     (col_q),
    .wr_data (pix_data),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(7)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .idx     (col_q),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (start) begin
      col_d   = '0;
      row_d   = '0;
      state_d = ST_FILL;
    end else if (accept) begin
      if (col_q == coord_t'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == coord_t'(IMG_H - 1)) ? '0 : row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
      state_d = (row_d >= 7'd2) ? ST_STREAM : ST_FILL;
    end
  end

  // Window shifts left; the new right-hand column is {oldest row, previous row, new pixel}.
  always_comb begin
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    if (start) begin
      out_valid_d = 1'b0;
    end else if (emit) begin
      out_valid_d = 1'b1;
      win_x_d     = col_q - 7'd1;
      win_y_d     = row_q - 7'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage p0 -> output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++) win_data[i*PIX_W +: PIX_W] = win_q[i];
  end

  assign out_valid  = out_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = out_valid_q && out_ready && !start &&
                      (win_x_q == coord_t'(IMG_W - 2)) && (win_y_q == coord_t'(IMG_H - 2));

endmodule
